// File: rtl/axis_stream_fifo.sv
// AXI-Stream synchronous FIFO, first-word-fall-through, with registered
// fill-level flags and a count of complete packets held.
module axis_stream_fifo #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = 12,
  parameter int AE_THRESH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tlast,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tlast,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [$clog2(DEPTH):0] count,
  output logic [$clog2(DEPTH):0] pkt_count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] AF_LVL  = (AW+1)'(AF_THRESH);
  localparam logic [AW:0] AE_LVL  = (AW+1)'(AE_THRESH);
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

  logic [DATA_W:0] mem [DEPTH];
  logic [AW:0]     wr_ptr, rd_ptr, wr_next, rd_next;
  logic [AW:0]     count_next, pkt_next;
  logic            ready_en;
  logic            push, pop, push_last, pop_last;

  // ready_en holds tready low through reset and releases it on the first edge after.
  assign s_axis_tready = ready_en && !full && !flush;
  assign m_axis_tvalid = !empty && !flush;
  assign push          = s_axis_tvalid && s_axis_tready;
  assign pop           = m_axis_tvalid && m_axis_tready;
  assign push_last     = push && s_axis_tlast;
  assign pop_last      = pop && m_axis_tlast;

  assign {m_axis_tlast, m_axis_tdata} = mem[rd_ptr[AW-1:0]];

  // NOTE: every output of this block is given a default first, so no path can infer a latch.
  always_comb begin
    wr_next    = wr_ptr;
    rd_next    = rd_ptr;
    count_next = count;
    pkt_next   = pkt_count;
    if (flush) begin
      wr_next    = '0;
      rd_next    = '0;
      count_next = '0;
      pkt_next   = '0;
    end else begin
      if (push) wr_next = wr_ptr + CNT_ONE;
      if (pop)  rd_next = rd_ptr + CNT_ONE;
      case ({push, pop})
        2'b10:   count_next = count + CNT_ONE;
        2'b01:   count_next = count - CNT_ONE;
        default: count_next = count;
      endcase
      if (push_last && !pop_last)      pkt_next = pkt_count + CNT_ONE;
      else if (pop_last && !push_last) pkt_next = pkt_count - CNT_ONE;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      pkt_count    <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      ready_en     <= 1'b0;
    end else begin
      wr_ptr       <= wr_next;
      rd_ptr       <= rd_next;
      count        <= count_next;
      pkt_count    <= pkt_next;
      full         <= (wr_next[AW] != rd_next[AW]) && (wr_next[AW-1:0] == rd_next[AW-1:0]);
      empty        <= (wr_next == rd_next);
      almost_full  <= (count_next >= AF_LVL);
      almost_empty <= (count_next <= AE_LVL);
      ready_en     <= 1'b1;
    end
  end

  // NOTE: storage has no reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {s_axis_tlast, s_axis_tdata};
  end

endmodule

// File: tb/tb_axis_stream_fifo.sv
// Randomised self-checking bench for axis_stream_fifo against a queue-based model.
module tb_axis_stream_fifo;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int AF     = 12;
  localparam int AE     = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic [DATA_W-1:0] s_axis_tdata;
  logic              s_axis_tlast;
  logic              s_axis_tvalid;
  logic              s_axis_tready;
  logic [DATA_W-1:0] m_axis_tdata;
  logic              m_axis_tlast;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic [4:0]        count;
  logic [4:0]        pkt_count;
  logic              full, empty, almost_full, almost_empty;

  int errors = 0;
  int checks = 0;

  // Reference model: queue of {tlast, tdata}, packet tally, ready-after-reset flag.
  logic [DATA_W:0] q[$];
  int              pkts = 0;
  bit              ready_en = 1'b0;

  localparam logic [15:0] RESET_VEC = 16'h0014;

  axis_stream_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .count(count), .pkt_count(pkt_count), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty)
  );

  always #5 clk = ~clk;

  // Expected {count, pkt_count, full, empty, almost_full, almost_empty, tready, tvalid} with idle inputs.
  function automatic logic [15:0] exp_vec();
    int n;
    n = q.size();
    return {5'(n), 5'(pkts), n == DEPTH, n == 0, n >= AF, n <= AE,
            ready_en && (n < DEPTH), n > 0};
  endfunction

  function automatic logic [15:0] dut_vec();
    return {count, pkt_count, full, empty, almost_full, almost_empty, s_axis_tready, m_axis_tvalid};
  endfunction

  task automatic idle_inputs();
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b0;
    flush         = 1'b0;
  endtask

  // Drive one clock of stimulus from just after a falling edge, update the model, return at the next falling edge.
  task automatic step(input logic sv, input logic [DATA_W-1:0] sd, input logic sl,
                      input logic mr, input logic fl);
    bit do_push, do_pop;
    s_axis_tvalid = sv;
    s_axis_tdata  = sd;
    s_axis_tlast  = sl;
    m_axis_tready = mr;
    flush         = fl;
    do_push = sv && !fl && ready_en && (q.size() < DEPTH);
    do_pop  = mr && !fl && (q.size() > 0);
    @(posedge clk);
    if (fl) begin
      q.delete();
      pkts = 0;
    end else begin
      if (do_pop) begin
        if (q[0][DATA_W]) pkts--;
        q.delete(0);
      end
      if (do_push) begin
        q.push_back({sl, sd});
        if (sl) pkts++;
      end
    end
    ready_en = 1'b1;
    #1 idle_inputs();
    @(negedge clk);
  endtask

  task automatic drain_compare(input string name);
    int guard;
    guard = 0;
    while (q.size() > 0 && guard < 2 * DEPTH) begin
      checks++;
      if (!m_axis_tvalid || {m_axis_tlast, m_axis_tdata} !== q[0]) begin
        errors++;
        $display("FAIL %s_drain valid=%0b got=%h exp=%h", name, m_axis_tvalid,
                 {m_axis_tlast, m_axis_tdata}, q[0]);
      end
      step(1'b0, '0, 1'b0, 1'b1, 1'b0);
      guard++;
    end
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL %s_drained state got=%h exp=%h", name, dut_vec(), exp_vec());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    checks++;
    if (dut_vec() !== RESET_VEC) begin
      errors++;
      $display("FAIL reset_state got=%h exp=%h", dut_vec(), RESET_VEC);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (s_axis_tready !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_ready got=%b exp=0", s_axis_tready);
    end
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (s_axis_tready !== 1'b1 || dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL reset_first_edge got=%h exp=%h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, DATA_W'(i), 1'b0, 1'b0, 1'b0);
      checks++;
      if (count !== 5'(i + 1) || almost_full !== (i + 1 >= 12)) begin
        errors++;
        $display("FAIL fill_level i=%0d count=%0d af=%b exp_count=%0d", i, count, almost_full, i + 1);
      end
    end
    checks++;
    if (full !== 1'b1 || s_axis_tready !== 1'b0 || count !== 5'd16) begin
      errors++;
      $display("FAIL fill_full full=%b ready=%b count=%0d exp 1/0/16", full, s_axis_tready, count);
    end
    step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
    checks++;
    if (count !== 5'd16) begin
      errors++;
      $display("FAIL fill_overpush count=%0d exp=16", count);
    end
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== DATA_W'(i)) begin
        errors++;
        $display("FAIL fill_order i=%0d valid=%b got=%h exp=%h", i, m_axis_tvalid, m_axis_tdata, i);
      end
      step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    end
    checks++;
    if (empty !== 1'b1 || m_axis_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL fill_empty empty=%b valid=%b exp 1/0", empty, m_axis_tvalid);
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 5; i++) step(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      checks++;
      if ({m_axis_tlast, m_axis_tdata} !== q[0]) begin
        errors++;
        $display("FAIL simul_head i=%0d got=%h exp=%h", i, {m_axis_tlast, m_axis_tdata}, q[0]);
      end
      step(1'b1, $urandom, 1'b0, 1'b1, 1'b0);
      checks++;
      if (count !== 5'd5) begin
        errors++;
        $display("FAIL simul_count i=%0d got=%0d exp=5", i, count);
      end
    end
    drain_compare("simul");
  endtask

  task automatic test_full_pop();
    logic [DATA_W-1:0] extra;
    for (int i = 0; i < DEPTH; i++) step(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
    extra = $urandom;
    step(1'b1, extra, 1'b0, 1'b1, 1'b0);
    checks++;
    if (count !== 5'd15 || full !== 1'b0 || s_axis_tready !== 1'b1) begin
      errors++;
      $display("FAIL full_pop_one count=%0d full=%b ready=%b exp 15/0/1", count, full, s_axis_tready);
    end
    step(1'b1, extra, 1'b0, 1'b0, 1'b0);
    checks++;
    if (count !== 5'd16 || full !== 1'b1) begin
      errors++;
      $display("FAIL full_pop_refill count=%0d full=%b exp 16/1", count, full);
    end
    drain_compare("full_pop");
  endtask

  task automatic test_packets();
    for (int p = 0; p < 3; p++)
      for (int b = 0; b < 4; b++) step(1'b1, $urandom, (b == 3), 1'b0, 1'b0);
    checks++;
    if (pkt_count !== 5'd3) begin
      errors++;
      $display("FAIL pkt_three got=%0d exp=3", pkt_count);
    end
    repeat (4) step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (pkt_count !== 5'd2) begin
      errors++;
      $display("FAIL pkt_after_pop got=%0d exp=2", pkt_count);
    end
    repeat (3) step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (pkt_count !== 5'd2 || m_axis_tlast !== 1'b1) begin
      errors++;
      $display("FAIL pkt_head_last pkt=%0d tlast=%b exp 2/1", pkt_count, m_axis_tlast);
    end
    step(1'b1, $urandom, 1'b1, 1'b1, 1'b0);
    checks++;
    if (pkt_count !== 5'd2 || count !== 5'd5) begin
      errors++;
      $display("FAIL pkt_both pkt=%0d count=%0d exp 2/5", pkt_count, count);
    end
    drain_compare("pkt");
  endtask

  task automatic test_flush();
    for (int i = 0; i < 9; i++) step(1'b1, $urandom, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    s_axis_tvalid = 1'b1;
    m_axis_tready = 1'b1;
    flush         = 1'b1;
    #1;
    checks++;
    if ({s_axis_tready, m_axis_tvalid} !== 2'b00) begin
      errors++;
      $display("FAIL flush_gating ready/valid got=%b exp=00", {s_axis_tready, m_axis_tvalid});
    end
    step(1'b1, $urandom, 1'b1, 1'b1, 1'b1);
    checks++;
    if (count !== 5'd0 || pkt_count !== 5'd0 || empty !== 1'b1 || dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL flush_clear got=%h exp=%h", dut_vec(), exp_vec());
    end
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (m_axis_tvalid !== 1'b0 || count !== 5'd0) begin
      errors++;
      $display("FAIL flush_no_ghost valid=%b count=%0d exp 0/0", m_axis_tvalid, count);
    end
  endtask

  task automatic test_async_reset();
    logic [DATA_W-1:0] first;
    for (int i = 0; i < 7; i++) step(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (dut_vec() !== RESET_VEC) begin
      errors++;
      $display("FAIL async_reset_immediate got=%h exp=%h", dut_vec(), RESET_VEC);
    end
    #1 rst = 1'b0;
    q.delete();
    pkts = 0;
    ready_en = 1'b0;
    @(negedge clk);
    ready_en = 1'b1;
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL async_reset_release got=%h exp=%h", dut_vec(), exp_vec());
    end
    first = $urandom;
    step(1'b1, first, 1'b0, 1'b0, 1'b0);
    step(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
    checks++;
    if (m_axis_tdata !== first || count !== 5'd2) begin
      errors++;
      $display("FAIL async_reset_first_beat got=%h count=%0d exp=%h/2", m_axis_tdata, count, first);
    end
    drain_compare("async");
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if (q.size() > 0) begin
        checks++;
        if (m_axis_tvalid !== 1'b1 || {m_axis_tlast, m_axis_tdata} !== q[0]) begin
          errors++;
          $display("FAIL random_head i=%0d valid=%b got=%h exp=%h", i, m_axis_tvalid,
                   {m_axis_tlast, m_axis_tdata}, q[0]);
        end
      end
      step($urandom_range(0, 99) < 60, $urandom, 1'($urandom_range(0, 3) == 0),
           $urandom_range(0, 99) < 50, $urandom_range(0, 63) == 0);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random_state i=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
    end
    drain_compare("random");
  endtask

  initial begin
    test_reset();
    test_fill();
    test_simultaneous();
    test_full_pop();
    test_packets();
    test_flush();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axis_stream_fifo.md
AXIS_STREAM_FIFO -- requirements
Module: axis_stream_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning the AXI-Stream tdata width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, meaning the number of storage entries; legal values are powers of two, 2 or greater.
REQ-003 SHALL have parameter AF_THRESH, default 12, meaning the fill level at or above which almost_full asserts.
REQ-004 SHALL have parameter AE_THRESH, default 4, meaning the fill level at or below which almost_empty asserts.
REQ-005 SHALL derive local parameter AW = $clog2(DEPTH).
REQ-006 SHALL have one clock and one reset: reset is asynchronous and active-high.
REQ-007 SHALL have these ports:
- clk  in  1  system clock; all logic on the rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous clear of contents
- s_axis_tdata  in  DATA_W  write data
- s_axis_tlast  in  1  write end-of-packet
- s_axis_tvalid  in  1  write valid
- s_axis_tready  out  1  write ready
- m_axis_tdata  out  DATA_W  read data
- m_axis_tlast  out  1  read end-of-packet
- m_axis_tvalid  out  1  read valid
- m_axis_tready  in  1  read ready
- count  out  AW+1  entries stored
- pkt_count  out  AW+1  complete packets stored (tlast beats held)
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_THRESH
- almost_empty  out  1  count <= AE_THRESH

Function
REQ-008 SHALL accept a beat (push) on a rising edge where s_axis_tvalid and s_axis_tready are both 1; SHALL drive s_axis_tready = !full && !flush.
REQ-009 SHALL remove a beat (pop) on a rising edge where m_axis_tvalid and m_axis_tready are both 1; SHALL drive m_axis_tvalid = !empty && !flush.
REQ-010 SHALL be first-word-fall-through: the head entry is driven on m_axis_tdata/m_axis_tlast whenever m_axis_tvalid is 1.
REQ-011 SHALL have no combinational bypass: a beat pushed into an empty FIFO at edge N is presented with m_axis_tvalid=1 from edge N onward (visible in cycle N+1), never in the push cycle.
REQ-012 SHALL use AW+1-bit read and write pointers that wrap modulo 2*DEPTH; storage index = pointer[AW-1:0]; full when the MSBs differ and the low bits are equal.
REQ-013 SHALL, on a simultaneous push and pop, leave count unchanged and advance both pointers.
REQ-014 SHALL never push when full and never pop when empty (guaranteed by the ready/valid gating); tdata/tlast SHALL NOT be stored in those cycles.
REQ-015 SHALL register count, full, empty, almost_full and almost_empty, all updated on the same edge as the push/pop that changes them.
REQ-016 SHALL increment pkt_count on a push with s_axis_tlast=1, decrement it on a pop with m_axis_tlast=1, and leave it unchanged when both happen in the same cycle.
REQ-017 SHALL, when flush=1 at a rising edge, set both pointers, count and pkt_count to 0 and discard any push or pop in that cycle; flush SHALL take priority over all other activity.
REQ-018 SHALL hold storage RAM contents undefined after reset or flush; only the pointers determine validity.
REQ-019 SHALL keep m_axis_tdata stable while m_axis_tvalid=1 and m_axis_tready=0.

Reset
REQ-020 SHALL, while rst=1 and independent of clk, drive count=0, pkt_count=0, empty=1, full=0, almost_empty=1, almost_full=0, s_axis_tready=0 and m_axis_tvalid=0, and reset both pointers to 0.
REQ-021 SHALL assert s_axis_tready on the first rising edge after rst deasserts; reset asserted mid-transfer SHALL drop all stored beats.

Verification
REQ-022 SHALL pass a fill test: DEPTH=16, push 16 beats 0x0..0xF with m_axis_tready=0 -> count=16, full=1, s_axis_tready=0, almost_full set at count 12; then drain -> beats read out in order 0x0..0xF, empty=1.
REQ-023 SHALL pass a simultaneous push/pop test: count=5, tvalid=tready=1 on both sides for 20 cycles -> count stays 5, output order is preserved, and the pointers wrap past 31 without error.
REQ-024 SHALL pass a full plus pop test: full FIFO, s_axis_tvalid=1 and m_axis_tready=1 for 1 cycle -> one pop, no push, count=15; the next cycle accepts the push.
REQ-025 SHALL pass a packet test: push 3 packets of 4 beats (tlast on beat 4) -> pkt_count=3; pop 4 beats -> pkt_count=2; a push-tlast and pop-tlast in the same cycle -> pkt_count is unchanged.
REQ-026 SHALL pass a flush test: count=9 with push and pop both asserted in the flush cycle -> next cycle count=0, pkt_count=0, empty=1, and no beat is emitted.
REQ-027 SHALL pass an asynchronous reset test: rst pulsed between clock edges at count=7 -> outputs take their reset values immediately; after rst deasserts, the first beat pushed is the first beat read.
